// File: rtl/riscv_dmem_resp_if.sv
// riscv_dmem_resp_if
// Bundles the CPU data-memory request/response signals between a requester
// (CPU dmem port) and the memory-side responder.
//
// Handshake: a request transfers on a rising clock edge where both
// i_dmem_req and o_dmem_ready are high. The request fields are sampled on
// that edge only and need not be held afterwards. Exactly one response
// follows each transfer as a single-cycle o_dmem_resp_valid pulse. The
// requester cannot stall it. o_dmem_resp_err is meaningful only with
// o_dmem_resp_valid, and o_dmem_rd_data only with o_dmem_resp_valid on a
// read response.
//
// Signals:
//   i_dmem_req        request valid
//   i_dmem_wr_en      1 = write, 0 = read
//   i_dmem_addr       byte address
//   i_dmem_wr_data    lane-aligned write data
//   i_dmem_byte_sel   byte-lane enables for writes
//   o_dmem_ready      responder can accept a request this cycle
//   o_dmem_resp_valid one-cycle response pulse
//   o_dmem_resp_err   response error flag
//   o_dmem_rd_data    read word
// Modports: master (requester side), slave (responder side).

`ifndef XLEN
`define XLEN 32
`endif

interface riscv_dmem_resp_if;
    logic              i_dmem_req;
    logic              i_dmem_wr_en;
    logic [`XLEN-1:0]  i_dmem_addr;
    logic [`XLEN-1:0]  i_dmem_wr_data;
    logic [3:0]        i_dmem_byte_sel;
    logic              o_dmem_ready;
    logic              o_dmem_resp_valid;
    logic              o_dmem_resp_err;
    logic [`XLEN-1:0]  o_dmem_rd_data;

    modport master (
        output i_dmem_req, i_dmem_wr_en, i_dmem_addr, i_dmem_wr_data, i_dmem_byte_sel,
        input  o_dmem_ready, o_dmem_resp_valid, o_dmem_resp_err, o_dmem_rd_data
    );

    modport slave (
        input  i_dmem_req, i_dmem_wr_en, i_dmem_addr, i_dmem_wr_data, i_dmem_byte_sel,
        output o_dmem_ready, o_dmem_resp_valid, o_dmem_resp_err, o_dmem_rd_data
    );
endinterface

// File: rtl/riscv_dmem_resp.sv
// riscv_dmem_resp
// Memory-side end of the CPU dmem interface. It holds a word-organised RAM
// and answers each accepted request with a one-cycle response. One request
// is outstanding at a time. Writes respond one cycle after accept. Reads
// respond RD_LATENCY cycles after accept.
//
// Parameters:
//   DMEM_DEPTH  RAM depth in 32-bit words (power of two, 16..65536)
//   RD_LATENCY  cycles from read accept to read response (1..8)
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst        asynchronous active-high reset
//   dmem         riscv_dmem_resp_if.slave request/response bundle
//   o_dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Optional feature macro RISCV_DMEM_ALIGN_CHK_EN adds a misalignment and
// byte_sel legality check on accept. Its error is ORed with the range
// error. Without the macro, only the range error is reported.

`ifndef XLEN
`define XLEN 32
`endif

module riscv_dmem_resp #(
    parameter int DMEM_DEPTH = 1024,
    parameter int RD_LATENCY = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    riscv_dmem_resp_if.slave dmem,
    output logic [1:0]       o_dbg_state
);
    localparam int AW = $clog2(DMEM_DEPTH);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     idx_q;
    logic              err_q;
    logic [`XLEN-1:0]  rd_data_q;

    logic              accept;
    logic              acc_err;
    logic              range_err;
    logic              align_err;
    logic              ram_we;
    logic [AW-1:0]     acc_idx;

    logic [`XLEN-1:0]  ram [DMEM_DEPTH];

    // Ready is low while in reset and while a read is still counting down.
    assign dmem.o_dmem_ready      = (state_q != WAIT) && !i_rst;
    assign dmem.o_dmem_resp_valid = (state_q == RESP);
    assign dmem.o_dmem_resp_err   = err_q && (state_q == RESP);
    assign dmem.o_dmem_rd_data    = rd_data_q;
    assign o_dbg_state            = state_q;

    assign accept  = dmem.i_dmem_req && dmem.o_dmem_ready;
    assign acc_idx = dmem.i_dmem_addr[AW+1:2];

    // Any set bit above the RAM's byte span puts the address out of range.
    assign range_err = |dmem.i_dmem_addr[`XLEN-1:AW+2];

`ifdef RISCV_DMEM_ALIGN_CHK_EN
    // Legal requests are a single lane anywhere, an aligned half in either
    // half of the word, or an aligned full word. Any other lane pattern,
    // including no lanes, is an error.
    always_comb begin
        align_err = 1'b1;
        case (dmem.i_dmem_byte_sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: align_err = 1'b0;
            4'b0011, 4'b1100:                   align_err = dmem.i_dmem_addr[0];
            4'b1111:                            align_err = |dmem.i_dmem_addr[1:0];
            default:                            align_err = 1'b1;
        endcase
    end
`else
    // The low address bits carry no information when lanes arrive aligned.
    logic unused_addr_lo;
    assign unused_addr_lo = ^dmem.i_dmem_addr[1:0];
    assign align_err      = 1'b0;
`endif

    assign acc_err = range_err || align_err;
    assign ram_we  = accept && dmem.i_dmem_wr_en && !acc_err;

    // IDLE and RESP both accept, which gives back-to-back service.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (dmem.i_dmem_wr_en || RD_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(RD_LATENCY - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q <= acc_idx;
                err_q <= acc_err;
                if (dmem.i_dmem_wr_en) begin
                    rd_data_q <= '0;
                end else if (RD_LATENCY == 1) begin
                    rd_data_q <= acc_err ? '0 : ram[acc_idx];
                end
            end else if (state_q == WAIT && cnt_q == CW'(1)) begin
                // The word is sampled on the edge into RESP. A write accepted
                // just before this read has already committed.
                rd_data_q <= err_q ? '0 : ram[idx_q];
            end
        end
    end

    // RAM contents survive reset by design, so this block has no reset.
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem.i_dmem_byte_sel[b]) begin
                    ram[acc_idx][8*b +: 8] <= dmem.i_dmem_wr_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_riscv_dmem_resp.sv
// tb_riscv_dmem_resp
// Bench for riscv_dmem_resp. Instance A uses RD_LATENCY 2 for directed and
// random traffic. Instance B uses RD_LATENCY 4 for the long-latency read and
// the reset-during-WAIT case. Expected responses come from a word-map model
// and pass through an expected queue.
module tb_riscv_dmem_resp;
    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);
    localparam int LAT_A = 2;
    localparam int LAT_B = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    riscv_dmem_resp_if if_a ();
    riscv_dmem_resp_if if_b ();
    logic [1:0] dbg_a, dbg_b;

    riscv_dmem_resp #(.DMEM_DEPTH(DEPTH), .RD_LATENCY(LAT_A)) u_dut_a (
        .i_clk(clk), .i_rst(rst_a), .dmem(if_a), .o_dbg_state(dbg_a)
    );
    riscv_dmem_resp #(.DMEM_DEPTH(DEPTH), .RD_LATENCY(LAT_B)) u_dut_b (
        .i_clk(clk), .i_rst(rst_b), .dmem(if_b), .o_dbg_state(dbg_b)
    );

    // Shared request fields, steered to one instance by use_b.
    logic        use_b, req, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;

    assign if_a.i_dmem_req      = req & ~use_b;
    assign if_a.i_dmem_wr_en    = wr;
    assign if_a.i_dmem_addr     = addr;
    assign if_a.i_dmem_wr_data  = wdata;
    assign if_a.i_dmem_byte_sel = sel;
    assign if_b.i_dmem_req      = req & use_b;
    assign if_b.i_dmem_wr_en    = wr;
    assign if_b.i_dmem_addr     = addr;
    assign if_b.i_dmem_wr_data  = wdata;
    assign if_b.i_dmem_byte_sel = sel;

    logic        m_ready, m_valid, m_err;
    logic [31:0] m_rd;
    assign m_ready = use_b ? if_b.o_dmem_ready      : if_a.o_dmem_ready;
    assign m_valid = use_b ? if_b.o_dmem_resp_valid : if_a.o_dmem_resp_valid;
    assign m_err   = use_b ? if_b.o_dmem_resp_err   : if_a.o_dmem_resp_err;
    assign m_rd    = use_b ? if_b.o_dmem_rd_data    : if_a.o_dmem_rd_data;

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [32:0] exp_q[$];
    logic [31:0] mem_m [int];
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Error rule from the memory map and, when enabled, the lane legality rule.
    function automatic logic exp_err(input logic [31:0] a, input logic [3:0] s);
        logic e;
        e = (a >= 32'(DEPTH * 4));
`ifdef RISCV_DMEM_ALIGN_CHK_EN
        if (!((s == 4'h1) || (s == 4'h2) || (s == 4'h4) || (s == 4'h8) ||
              (((s == 4'h3) || (s == 4'hC)) && !a[0]) ||
              ((s == 4'hF) && (a[1:0] == 2'b00))))
            e = 1'b1;
`else
        if (s == 4'hF && s == 4'h0) e = 1'b1;
`endif
        return e;
    endfunction

    // ---------------- driver ----------------
    // Entered on a negedge. Issues one request, predicts its response,
    // and returns on the negedge of the response cycle.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        int          guard;
        int          lat;
        int          key;
        logic        e;
        logic [31:0] word;
        logic [32:0] exp;
        e   = exp_err(a, s);
        key = (use_b ? 65536 : 0) + int'(a[AW+1:2]);
        if (w) begin
            if (!e) begin
                word = mem_m.exists(key) ? mem_m[key] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (s[b]) word[8*b +: 8] = d[8*b +: 8];
                mem_m[key] = word;
            end
            exp_q.push_back({e, 32'h0});
        end else begin
            exp_q.push_back({e, (e || !mem_m.exists(key)) ? 32'h0 : mem_m[key]});
        end

        guard = 0;
        while (!m_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!m_ready) begin
            check("ready_timeout", {63'h0, m_ready}, 64'h1);
            void'(exp_q.pop_back());
            return;
        end

        req = 1'b1; wr = w; addr = a; wdata = d; sel = s;
        @(posedge clk);
        #1;
        req = 1'b0;
        wdata = $urandom;

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_valid && lat < 16);
        check("latency", 64'(lat), 64'(w ? 1 : (use_b ? LAT_B : LAT_A)));
        exp = exp_q.pop_front();
        if (m_valid) begin
            check(w ? "wr_resp" : "rd_resp", {31'h0, m_err, m_rd}, {31'h0, exp});
            last_rd = m_rd;
        end else begin
            check("resp_timeout", 64'h0, 64'h1);
        end
    endtask

    // One idle cycle after a response: the pulse must have ended.
    task automatic gap();
        @(negedge clk);
        check("pulse_end", {62'h0, m_valid, m_ready}, 64'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic        w;
        logic [31:0] ra;
        logic [3:0]  s;
        int          cnt;

        use_b = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sel = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", {63'h0, m_ready}, 64'h0);
        check("rst_valid", {62'h0, m_valid, m_err}, 64'h0);
        check("rst_rd", 64'(m_rd), 64'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {63'h0, m_ready}, 64'h1);
        check("post_rst_state", 64'(dbg_a), 64'h0);

        // Known contents for words 0..15.
        for (int i = 0; i < 16; i++) begin
            do_req(1'b1, 32'(i * 4), $urandom, 4'hF);
            gap();
        end

        // Full write, read back, then a single-lane merge.
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF); gap();
        do_req(1'b0, 32'h10, 32'h0, 4'hF);        gap();
        check("full_word", 64'(last_rd), 64'hDEADBEEF);
        do_req(1'b1, 32'h10, 32'h0000AB00, 4'b0010); gap();
        do_req(1'b0, 32'h10, 32'h0, 4'hF);           gap();
        check("lane_merge", 64'(last_rd), 64'hDEADABEF);

        // Back-to-back: write, write in its RESP cycle, then read in the next RESP.
        do_req(1'b1, 32'h1C, 32'h0BADF00D, 4'hF);
        check("b2b_ready0", {63'h0, m_ready}, 64'h1);
        do_req(1'b1, 32'h20, 32'h12345678, 4'hF);
        check("b2b_ready1", {63'h0, m_ready}, 64'h1);
        do_req(1'b0, 32'h20, 32'h0, 4'hF);
        gap();
        check("b2b_raw", 64'(last_rd), 64'h12345678);

        // Out of range read and write; word 0 must be untouched.
        do_req(1'b0, 32'h1000, 32'h0, 4'hF);         gap();
        do_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);  gap();
        do_req(1'b0, 32'h0, 32'h0, 4'hF);            gap();

        // Misaligned full word and an empty lane mask.
        do_req(1'b1, 32'h22, 32'hA5A5A5A5, 4'hF); gap();
        do_req(1'b0, 32'h20, 32'h0, 4'hF);        gap();
        do_req(1'b1, 32'h24, 32'h5A5A5A5A, 4'h0); gap();
        do_req(1'b0, 32'h24, 32'h0, 4'hF);        gap();

        // Random traffic with random back-to-back issue.
        for (int i = 0; i < 200; i++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       ra = 32'h1000 + 32'($urandom_range(0, 4095));
                1:       ra = 32'hF000_0000 | 32'($urandom_range(0, 65535));
                default: ra = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 3))
                0:       s = 4'hF;
                1:       s = 4'(1 << $urandom_range(0, 3));
                2:       s = $urandom_range(0, 1) ? 4'h3 : 4'hC;
                default: s = 4'($urandom_range(0, 15));
            endcase
            do_req(w, ra, $urandom, s);
            if ($urandom_range(0, 2) != 0) gap();
        end
        gap();

        // Instance B: latency-4 read, then reset during WAIT.
        use_b = 1'b1;
        @(negedge clk);
        do_req(1'b1, 32'h40, 32'hCAFEF00D, 4'hF); gap();
        do_req(1'b0, 32'h40, 32'h0, 4'hF);        gap();
        check("lat4_data", 64'(last_rd), 64'hCAFEF00D);

        req = 1'b1; wr = 1'b0; addr = 32'h40; sel = 4'hF;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check("in_wait_state", 64'(dbg_b), 64'h1);
        check("in_wait_ready", {63'h0, m_ready}, 64'h0);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_valid) cnt++;
        end
        check("dropped_resp", 64'(cnt), 64'h0);
        check("after_rst_ready", {63'h0, m_ready}, 64'h1);
        do_req(1'b0, 32'h40, 32'h0, 4'hF); gap();
        check("kept_after_rst", 64'(last_rd), 64'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
